// File: rtl/tube_scan_capture.sv
// Receive-side monitor for the scanned 8-digit seven-segment bus. It decodes
// settled digit patterns back to codes and assembles them into BCD time frames.
module tube_digit_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       clr,
  input  logic [3:0] code,
  input  logic       dp_in,
  output logic [3:0] dig,
  output logic       dp,
  output logic       vld
);
  always_ff @(posedge clk) begin
    if (rst) begin
      dig <= 4'hE;
      dp  <= 1'b0;
      vld <= 1'b0;
    end else begin
      if (wr) begin
        dig <= code;
        dp  <= dp_in;
      end
      // A write in the clearing cycle belongs to the next frame.
      if (wr)       vld <= 1'b1;
      else if (clr) vld <= 1'b0;
    end
  end
endmodule

module tube_scan_capture #(
  parameter int SETTLE        = 4,
  parameter int TIMEOUT       = 65535,
  parameter int TW            = 16,
  parameter int STABLE_FRAMES = 2
) (
  input  logic       CP,
  input  logic       CR,
  input  logic [7:0] SEG,
  input  logic [7:0] CODEOUT,
  output logic [7:0] Q_H,
  output logic [7:0] Q_M,
  output logic [7:0] Q_S,
  output logic [7:0] MODE,
  output logic [7:0] DP,
  output logic       FRAME,
  output logic       STABLE,
  output logic       ERR,
  output logic       LOST
);
  localparam int NUM_DIG = 8;
  localparam int CW      = $clog2(SETTLE + 1);
  localparam int MW      = $clog2(STABLE_FRAMES + 1);

  typedef enum logic {S_COLLECT, S_COMMIT} state_t;

  logic [7:0] seg_s1, seg_s2, seg_p;
  logic [7:0] cod_s1, cod_s2, cod_p;
  logic [CW-1:0] cnt, cnt_eff;
  logic [TW-1:0] tcnt;
  logic [MW-1:0] mcnt;
  logic          change, sel_ok, sample, lost_fire, clr_mask, commit;
  logic [4:0]    dec;
  logic [NUM_DIG-1:0]      wr_vec, mask, dp_v;
  logic [NUM_DIG-1:0][3:0] dig;
  state_t state, state_nxt;

  function automatic logic [4:0] dec7(input logic [6:0] p);
    case (p)
      7'h40:   return 5'h00;
      7'h79:   return 5'h01;
      7'h24:   return 5'h02;
      7'h30:   return 5'h03;
      7'h19:   return 5'h04;
      7'h12:   return 5'h05;
      7'h02:   return 5'h06;
      7'h78:   return 5'h07;
      7'h00:   return 5'h08;
      7'h10:   return 5'h09;
      7'h7F:   return 5'h0E;
      default: return 5'h1F;  // bit 4 flags an undecodable pattern
    endcase
  endfunction

  always_ff @(posedge CP) begin
    if (CR) begin
      seg_s1 <= '0; seg_s2 <= '0; seg_p <= '0;
      cod_s1 <= '0; cod_s2 <= '0; cod_p <= '0;
    end else begin
      seg_s1 <= SEG;    seg_s2 <= seg_s1; seg_p <= seg_s2;
      cod_s1 <= CODEOUT; cod_s2 <= cod_s1; cod_p <= cod_s2;
    end
  end

  // cnt_eff counts the current cycle as the first stable one after a change,
  // so a digit is sampled on its SETTLE-th synced cycle.
  assign change  = {seg_s2, cod_s2} != {seg_p, cod_p};
  assign sel_ok  = $onehot(~seg_s2);
  assign cnt_eff = change ? '0 : cnt;
  assign sample  = sel_ok && (cnt_eff == CW'(SETTLE - 1));
  assign wr_vec  = sample ? ~seg_s2 : '0;
  assign dec     = dec7(cod_s2[6:0]);

  always_ff @(posedge CP) begin
    if (CR)                         cnt <= '0;
    else if (!sel_ok)               cnt <= '0;
    else if (cnt_eff != CW'(SETTLE)) cnt <= cnt_eff + 1'b1;
    else                            cnt <= cnt_eff;
  end

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_slot
    tube_digit_slot u_slot (
      .clk  (CP),
      .rst  (CR),
      .wr   (wr_vec[g]),
      .clr  (clr_mask),
      .code (dec[3:0]),
      .dp_in(~cod_s2[7]),
      .dig  (dig[g]),
      .dp   (dp_v[g]),
      .vld  (mask[g])
    );
  end

  // Enter COMMIT on the sample that completes the mask, so outputs and FRAME
  // appear the cycle after the last digit is captured.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      S_COLLECT: if (&(mask | wr_vec)) state_nxt = S_COMMIT;
      S_COMMIT: begin
        commit    = 1'b1;
        state_nxt = S_COLLECT;
      end
      default: state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge CP) begin
    if (CR) state <= S_COLLECT;
    else    state <= state_nxt;
  end

  assign lost_fire = !sample && (tcnt == TW'(TIMEOUT - 1));
  assign clr_mask  = commit | lost_fire;
  assign STABLE    = mcnt >= MW'(STABLE_FRAMES);

  always_ff @(posedge CP) begin
    if (CR) begin
      tcnt  <= '0;
      mcnt  <= '0;
      Q_H   <= 8'hEE;
      Q_M   <= 8'hEE;
      Q_S   <= 8'hEE;
      MODE  <= 8'hEE;
      DP    <= '0;
      FRAME <= 1'b0;
      ERR   <= 1'b0;
      LOST  <= 1'b0;
    end else begin
      FRAME <= commit;
      if (sample)          tcnt <= '0;
      else if (!lost_fire) tcnt <= tcnt + 1'b1;
      if (sample && dec[4]) ERR <= 1'b1;
      if (lost_fire) begin
        LOST <= 1'b1;
        mcnt <= '0;
      end
      if (commit) begin
        Q_H  <= {dig[5], dig[4]};
        Q_M  <= {dig[3], dig[2]};
        Q_S  <= {dig[1], dig[0]};
        MODE <= {dig[7], dig[6]};
        DP   <= dp_v;
        LOST <= 1'b0;
        if ({dig, dp_v} == {MODE, Q_H, Q_M, Q_S, DP})
          mcnt <= (mcnt == MW'(STABLE_FRAMES)) ? mcnt : mcnt + 1'b1;
        else
          mcnt <= MW'(1);
      end
    end
  end
endmodule

// File: tb/tb_tube_scan_capture.sv
// Bench for tube_scan_capture: drives scanned digit patterns and checks the
// assembled frames against a digit-level model of the display.
module tb_tube_scan_capture;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;

  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic [7:0] SEG = 8'hFF, CODEOUT = 8'hFF;
  logic [7:0] Q_H, Q_M, Q_S, MODE, DP;
  logic       FRAME, STABLE, ERR, LOST;

  tube_scan_capture #(
    .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .TW(16), .STABLE_FRAMES(2)
  ) dut (
    .CP(CP), .CR(CR), .SEG(SEG), .CODEOUT(CODEOUT),
    .Q_H(Q_H), .Q_M(Q_M), .Q_S(Q_S), .MODE(MODE), .DP(DP),
    .FRAME(FRAME), .STABLE(STABLE), .ERR(ERR), .LOST(LOST)
  );

  always #5 CP = ~CP;

  int vec = 0, errs = 0, cyc = 0;
  int d_frames = 0, m_frames = 0, frame_cyc = -1, last_sample = 0, m_cnt = 0;
  int fb = 0, lost_cyc = -1;
  logic [31:0] c_digits, m_prev_d, rv, pv;
  logic [7:0]  c_dp, m_prev_dp, m_dp, m_mask, rdp;
  logic [7:0][3:0] m_dig;
  logic        m_err, m_lost;

  function automatic logic [6:0] pat(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24;
      4'h3: return 7'h30; 4'h4: return 7'h19; 4'h5: return 7'h12;
      4'h6: return 7'h02; 4'h7: return 7'h78; 4'h8: return 7'h00;
      4'h9: return 7'h10; default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [7:0] sel(input int d);
    logic [7:0] s;
    s = 8'hFF;
    s[d] = 1'b0;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    cyc++;
    #1;
    if (FRAME === 1'b1) begin
      d_frames++;
      c_digits  = {MODE, Q_H, Q_M, Q_S};
      c_dp      = DP;
      frame_cyc = cyc;
    end
  endtask

  task automatic model_reset();
    m_prev_d = 32'hEEEEEEEE; m_prev_dp = 8'h00; m_cnt = 0;
    m_err = 1'b0; m_lost = 1'b0; m_mask = 8'h00; m_dp = 8'h00;
    m_dig = '0;
  endtask

  task automatic model_commit();
    if ({m_dig, m_dp} == {m_prev_d, m_prev_dp}) m_cnt++;
    else m_cnt = 1;
    m_prev_d = m_dig; m_prev_dp = m_dp;
    m_frames++; m_lost = 1'b0; m_mask = 8'h00;
  endtask

  // One held pattern of n cycles; it is captured if the select is a single
  // digit and the pattern lasts at least SETTLE cycles.
  task automatic step(input logic [7:0] s, input logic [7:0] code, input int n, input logic [3:0] expv);
    int c0, d;
    SEG = s; CODEOUT = code; c0 = cyc;
    if (n >= SETTLE && $countones(~s) == 1) begin
      d = 0;
      for (int i = 0; i < 8; i++) if (!s[i]) d = i;
      m_dig[d] = expv; m_dp[d] = ~code[7]; m_mask[d] = 1'b1;
      if (expv == 4'hF) m_err = 1'b1;
      last_sample = c0 + SETTLE + 2;
      if (&m_mask) model_commit();
    end
    repeat (n) tick();
  endtask

  // Full scan of digits 7..0; hold 0 means a random hold per digit.
  task automatic scan(input logic [31:0] vals, input logic [7:0] dps, input int hold,
                      input bit glitch, input int bad_d, input int gap);
    logic [3:0] v, g;
    for (int d = 7; d >= 0; d--) begin
      v = vals[d*4 +: 4];
      if (glitch && $urandom_range(0, 1) == 1) begin
        g = (v >= 4'h9) ? 4'h0 : v + 4'h1;
        step(sel(d), {~dps[d], pat(g)}, $urandom_range(1, SETTLE - 1), g);
      end
      if (d == bad_d) step(sel(d), 8'h7E, hold, 4'hF);
      else step(sel(d), {~dps[d], pat(v)}, (hold == 0) ? $urandom_range(4, 10) : hold, v);
    end
    step(8'hFF, 8'hFF, gap, 4'h0);
  endtask

  task automatic do_reset();
    CR = 1'b1; SEG = 8'hFF; CODEOUT = 8'hFF;
    repeat (2) tick();
    CR = 1'b0;
    model_reset();
  endtask

  task automatic check_frame(input string tag);
    chk({tag, ":frames"}, d_frames, m_frames);
    chk({tag, ":digits"}, {MODE, Q_H, Q_M, Q_S}, m_prev_d);
    chk({tag, ":dp"}, {24'h0, DP}, {24'h0, m_prev_dp});
    chk({tag, ":stable"}, {31'h0, STABLE}, {31'h0, m_cnt >= 2});
    chk({tag, ":err"}, {31'h0, ERR}, {31'h0, m_err});
    chk({tag, ":lost"}, {31'h0, LOST}, {31'h0, m_lost});
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("rst:digits", {MODE, Q_H, Q_M, Q_S}, 32'hEEEEEEEE);
    chk("rst:dp", {24'h0, DP}, 32'h0);
    chk("rst:flags", {28'h0, FRAME, STABLE, ERR, LOST}, 32'h0);

    // 12:34:56, blank mode digits
    scan(32'hEE123456, 8'h00, 8, 0, -1, 6);
    check_frame("f1");
    chk("f1:qh", {24'h0, Q_H}, 32'h12);
    chk("f1:qm", {24'h0, Q_M}, 32'h34);
    chk("f1:qs", {24'h0, Q_S}, 32'h56);
    chk("f1:mode", {24'h0, MODE}, 32'hEE);
    chk("f1:latency", frame_cyc, last_sample + 1);
    chk("f1:cap", c_digits, 32'hEE123456);

    scan(32'hEE123456, 8'h00, 8, 0, -1, 6);
    check_frame("f2");
    chk("f2:stable", {31'h0, STABLE}, 32'h1);

    scan(32'hEE123457, 8'h00, 8, 0, -1, 6);
    check_frame("f3");
    chk("f3:stable", {31'h0, STABLE}, 32'h0);

    // digit 0 held only 3 cycles, then rescanned properly
    fb = d_frames;
    for (int d = 7; d >= 1; d--) step(sel(d), {1'b1, pat(m_prev_d[d*4 +: 4])}, 8, m_prev_d[d*4 +: 4]);
    step(sel(0), {1'b1, pat(4'h8)}, 3, 4'h8);
    step(8'hFF, 8'hFF, 10, 4'h0);
    chk("short:noframe", d_frames, fb);
    step(sel(0), {1'b1, pat(4'h8)}, 8, 4'h8);
    step(8'hFF, 8'hFF, 4, 4'h0);
    check_frame("short");
    chk("short:qs", {24'h0, Q_S}, 32'h58);

    // undecodable pattern on digit 2
    scan(32'hEE123456, 8'h00, 8, 0, 2, 6);
    check_frame("bad");
    chk("bad:qm", {24'h0, Q_M}, 32'h3F);
    chk("bad:err", {31'h0, ERR}, 32'h1);
    chk("bad:dp2", {31'h0, DP[2]}, 32'h1);
    scan(32'hEE123456, 8'h00, 8, 0, -1, 6);
    scan(32'hEE123456, 8'h00, 8, 0, -1, 6);
    check_frame("sticky");
    chk("sticky:err", {31'h0, ERR}, 32'h1);

    // scanning stops: LOST after TIMEOUT cycles, outputs held
    SEG = 8'hFF; CODEOUT = 8'hFF;
    lost_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (LOST === 1'b1) begin
        lost_cyc = cyc;
        break;
      end
    end
    chk("lost:time", lost_cyc, last_sample + TIMEOUT);
    m_lost = 1'b1; m_cnt = 0; m_mask = 8'h00;
    check_frame("lost");
    scan(32'hEE123456, 8'h00, 8, 0, -1, 6);
    check_frame("resume");
    chk("resume:lost", {31'h0, LOST}, 32'h0);

    // reset after five digits
    for (int d = 7; d >= 3; d--) step(sel(d), {1'b1, pat(4'h7)}, 8, 4'h7);
    do_reset();
    chk("mid:digits", {MODE, Q_H, Q_M, Q_S}, 32'hEEEEEEEE);
    chk("mid:flags", {28'h0, FRAME, STABLE, ERR, LOST}, 32'h0);
    fb = d_frames;
    scan(32'hEE095959, 8'h00, 8, 0, -1, 6);
    chk("mid:one", d_frames - fb, 1);
    check_frame("mid");

    // random frames, with glitches and repeats
    rv = 32'hEE000000; rdp = 8'h00;
    for (int f = 0; f < 16; f++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int d = 0; d < 8; d++) begin
          pv = $urandom_range(0, 10);
          rv[d*4 +: 4] = (pv == 10) ? 4'hE : pv[3:0];
        end
        rdp = 8'($urandom_range(0, 255));
      end
      scan(rv, rdp, 0, 1, -1, $urandom_range(4, 8));
      check_frame("rand");
      chk("rand:cap", c_digits, m_prev_d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
